// File: rtl/demux_1_to_4_buffered_pkg.sv
// Shared constants for the buffered 1:4 word demux.
// Lane encodings and the select-to-one-hot decoder.
package demux_pkg;

  localparam int LANE_COUNT = 4;

  localparam logic [1:0] LANE1 = 2'b00;
  localparam logic [1:0] LANE2 = 2'b01;
  localparam logic [1:0] LANE3 = 2'b10;
  localparam logic [1:0] LANE4 = 2'b11;

  function automatic logic [LANE_COUNT-1:0] lane_onehot(
    input logic [1:0] sel
  );
    logic [LANE_COUNT-1:0] oh;
    oh = '0;
    unique case (1'b1)
      (sel == LANE1): oh = 4'b0001;
      (sel == LANE2): oh = 4'b0010;
      (sel == LANE3): oh = 4'b0100;
      (sel == LANE4): oh = 4'b1000;
      default:        oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_1_to_4_buffered_if.sv
// Producer/consumer bundle of the buffered 1:4 demux.
// master = traffic side, slave = the demux itself.
interface demux_1_to_4_buffered_if #(
  parameter int WORD_WIDTH = 32
);

  logic [1:0]            select;
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] inp;
  logic [3:0]            out_valid;
  logic [3:0]            out_ready;
  logic [WORD_WIDTH-1:0] out1;
  logic [WORD_WIDTH-1:0] out2;
  logic [WORD_WIDTH-1:0] out3;
  logic [WORD_WIDTH-1:0] out4;
  logic                  busy;

  modport master (
    output select,
    output in_valid,
    output inp,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out1,
    input  out2,
    input  out3,
    input  out4,
    input  busy
  );

  modport slave (
    input  select,
    input  in_valid,
    input  inp,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out1,
    output out2,
    output out3,
    output out4,
    output busy
  );

endinterface

// File: rtl/demux_1_to_4_buffered_lane_fifo.sv
// Per-lane FIFO with pop-through when full.
// Outputs read as empty/zero while rst is high.
module demux_lane_fifo #(
  parameter int WORD_WIDTH = 32,
  parameter int LANE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WORD_WIDTH-1:0] din,
  output logic                  full,
  input  logic                  pop,
  output logic [WORD_WIDTH-1:0] dout,
  output logic                  empty
);

  localparam int PW = (LANE_DEPTH > 1) ? $clog2(LANE_DEPTH) : 1;
  localparam int CW = $clog2(LANE_DEPTH + 1);

  logic [WORD_WIDTH-1:0] mem_q [LANE_DEPTH];
  logic [PW-1:0]         wptr_q;
  logic [PW-1:0]         wptr_d;
  logic [PW-1:0]         rptr_q;
  logic [PW-1:0]         rptr_d;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic                  do_push;
  logic                  do_pop;

  assign empty = rst || (cnt_q == '0);
  assign full  = !rst && (cnt_q == CW'(LANE_DEPTH));
  assign dout  = rst ? '0 : mem_q[rptr_q];

  // A full lane may still accept a word when its head leaves this cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && !rst && (!full || do_pop);

  always_comb begin
    wptr_d = wptr_q + PW'(do_push);
    rptr_d = rptr_q + PW'(do_pop);
    cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < LANE_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (do_push) begin
        mem_q[wptr_q] <= din;
      end
    end
  end

endmodule

// File: rtl/demux_1_to_4_buffered.sv
// Buffered 1:4 word demux: one producer, four lane FIFOs.
// Top holds only push decode, in_ready mux and busy.
module demux_1_to_4_buffered
  import demux_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int LANE_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  demux_1_to_4_buffered_if.slave    bus
);

  logic [LANE_COUNT-1:0] full;
  logic [LANE_COUNT-1:0] empty;
  logic [LANE_COUNT-1:0] push;
  logic [LANE_COUNT-1:0] pop;
  logic [WORD_WIDTH-1:0] dout [LANE_COUNT];
  logic                  rdy;

  // Independent of in_valid so the producer can wait on it.
  assign rdy = !full[bus.select] || bus.out_ready[bus.select];

  assign push = lane_onehot(bus.select)
              & {LANE_COUNT{bus.in_valid && rdy}};
  assign pop  = bus.out_ready & ~empty;

  for (genvar g = 0; g < LANE_COUNT; g++) begin : g_lane
    demux_lane_fifo #(
      .WORD_WIDTH (WORD_WIDTH),
      .LANE_DEPTH (LANE_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .din   (bus.inp),
      .full  (full[g]),
      .pop   (pop[g]),
      .dout  (dout[g]),
      .empty (empty[g])
    );
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = ~empty;
  assign bus.busy      = |(~empty);
  assign bus.out1      = dout[0];
  assign bus.out2      = dout[1];
  assign bus.out3      = dout[2];
  assign bus.out4      = dout[3];

endmodule

// File: tb/tb_demux_1_to_4_buffered.sv
// Directed + random bench for demux_1_to_4_buffered.
// Per-lane queues hold expected words; heads compared every cycle.
module tb_demux_1_to_4_buffered;

  localparam int W     = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] q [4][$];

  demux_1_to_4_buffered_if #(.WORD_WIDTH(W)) bus ();

  demux_1_to_4_buffered #(
    .WORD_WIDTH (W),
    .LANE_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [W-1:0] outs [4];
    logic         exp_rdy;
    int           s;
    @(negedge clk);
    outs[0] = bus.out1;
    outs[1] = bus.out2;
    outs[2] = bus.out3;
    outs[3] = bus.out4;
    if (rst) begin
      chk("rst_out_valid", W'(bus.out_valid), '0);
      chk("rst_busy", W'(bus.busy), '0);
      chk("rst_in_ready", W'(bus.in_ready), 1);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("rst_out%0d", i + 1), outs[i], '0);
        q[i].delete();
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("out_valid%0d", i + 1),
            W'(bus.out_valid[i]), W'(q[i].size() != 0));
        if (q[i].size() != 0)
          chk($sformatf("out%0d", i + 1), outs[i], q[i][0]);
      end
      chk("busy", W'(bus.busy),
          W'(q[0].size() + q[1].size() + q[2].size() + q[3].size() != 0));
      s = int'(bus.select);
      exp_rdy = (q[s].size() < DEPTH) || bus.out_ready[s];
      chk("in_ready", W'(bus.in_ready), W'(exp_rdy));
      for (int i = 0; i < 4; i++) begin
        if (q[i].size() != 0 && bus.out_ready[i])
          void'(q[i].pop_front());
      end
      if (bus.in_valid && exp_rdy)
        q[s].push_back(bus.inp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel,
                       input logic [W-1:0] d, input logic [3:0] ordy);
    bus.in_valid  = v;
    bus.select    = sel;
    bus.inp       = d;
    bus.out_ready = ordy;
  endtask

  initial begin
    drive(1'b1, 2'b00, 32'hDEAD_BEEF, 4'b0000);

    // 1. reset with in_valid held high
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    drive(1'b0, 2'b00, '0, 4'b0000);
    chk("post_rst_out_valid", W'(bus.out_valid), '0);
    chk("post_rst_in_ready", W'(bus.in_ready), 1);

    // 2. routing one word per lane
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 32'hA0 + W'(i), 4'b0000);
      cyc();
    end
    drive(1'b0, 2'b00, '0, 4'b0000);
    chk("route_valid", W'(bus.out_valid), 32'hF);
    chk("route_out1", bus.out1, 32'hA0);
    chk("route_out4", bus.out4, 32'hA3);
    drive(1'b0, 2'b00, '0, 4'b1111);
    cyc();
    drive(1'b0, 2'b00, '0, 4'b0000);
    chk("route_drained", W'(bus.out_valid), '0);

    // 3. fill lane 1, then pop-through
    drive(1'b1, 2'b00, 32'h11, 4'b0000);
    cyc();
    drive(1'b1, 2'b00, 32'h22, 4'b0000);
    cyc();
    drive(1'b1, 2'b00, 32'h33, 4'b0000);
    #1;
    chk("full_blocks", W'(bus.in_ready), 0);
    cyc();
    drive(1'b1, 2'b00, 32'h33, 4'b0001);
    #1;
    chk("pop_through_rdy", W'(bus.in_ready), 1);
    cyc();
    drive(1'b0, 2'b00, '0, 4'b0001);
    chk("pop_through_head", bus.out1, 32'h22);
    cyc();
    chk("pop_through_tail", bus.out1, 32'h33);
    cyc();
    drive(1'b0, 2'b00, '0, 4'b0000);

    // 4. push and pop lane 2 together
    drive(1'b1, 2'b01, 32'hB1, 4'b0000);
    cyc();
    drive(1'b1, 2'b01, 32'hB2, 4'b0010);
    cyc();
    drive(1'b0, 2'b00, '0, 4'b0000);
    chk("same_cycle_valid", W'(bus.out_valid), 32'h2);
    chk("same_cycle_out2", bus.out2, 32'hB2);
    drive(1'b0, 2'b00, '0, 4'b0010);
    cyc();
    drive(1'b0, 2'b00, '0, 4'b0000);
    chk("same_cycle_cnt1", W'(bus.out_valid), '0);

    // 5. switch select while blocked
    drive(1'b1, 2'b10, 32'hC1, 4'b0000);
    cyc();
    drive(1'b1, 2'b10, 32'hC2, 4'b0000);
    cyc();
    drive(1'b1, 2'b10, 32'hC3, 4'b0000);
    cyc();
    drive(1'b1, 2'b00, 32'hC3, 4'b0000);
    cyc();
    drive(1'b0, 2'b00, '0, 4'b0000);
    chk("switch_valid", W'(bus.out_valid), 32'h5);
    chk("switch_out1", bus.out1, 32'hC3);
    chk("switch_out3", bus.out3, 32'hC1);
    drive(1'b0, 2'b00, '0, 4'b1111);
    cyc();
    cyc();
    drive(1'b0, 2'b00, '0, 4'b0000);

    // 6. random traffic, then a mid-stream reset
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            W'($urandom), 4'($urandom_range(0, 15)));
      cyc();
    end
    drive(1'b1, 2'($urandom_range(0, 3)), W'($urandom), 4'b0000);
    cyc();
    rst = 1'b1;
    drive(1'b1, 2'b01, 32'h5555, 4'b1111);
    cyc();
    rst = 1'b0;
    drive(1'b0, 2'b00, '0, 4'b0000);
    chk("midrst_valid", W'(bus.out_valid), '0);
    chk("midrst_busy", W'(bus.busy), '0);
    drive(1'b1, 2'b11, 32'hD4, 4'b0000);
    cyc();
    drive(1'b0, 2'b00, '0, 4'b0000);
    chk("midrst_latency", W'(bus.out_valid), 32'h8);
    chk("midrst_out4", bus.out4, 32'hD4);
    drive(1'b0, 2'b00, '0, 4'b1111);
    cyc();
    cyc();
    chk("final_idle", W'(bus.busy), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
